filter_out_requant: RTL and testbench

Downstream stage of the IIR filter. Consumes the filter's 32-bit signed Q16.16 result and produces 16-bit signed Q8.8 samples, the same format as the filter input, for the DAC/output path.
- Rounds half-up, saturates to the output range and flags clipped samples.
- Buffers results in a small FIFO behind a valid/ready handshake, so the consumer may stall without losing samples.

---
 rtl/filter_out_requant.sv | 121 ++++++++++++
 tb/tb_filter_out_requant.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_out_requant.sv
// Requantises the IIR filter's Q16.16 result to Q8.8 with round-half-up and saturation,
// then buffers samples in a credit-controlled first-word-fall-through FIFO.
module filter_out_requant #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             clr_count,
  output logic [15:0]      sat_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CW:0]          DEPTH_C = (CW+1)'(DEPTH);

  // One extra bit of headroom keeps the rounding add from wrapping at the positive limit.
  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] sum;
    sum = {x[IN_W-1], x} + HALF;
    return sum >>> SHIFT;
  endfunction

  // Returns {sat, data}.
  function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] q);
    if (q > MAXV)
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    else if (q < MINV)
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, q[OUT_W-1:0]};
  endfunction

  logic signed [IN_W:0]    q_p1;
  logic                    vld_p1;
  logic signed [OUT_W-1:0] data_p2;
  logic                    sat_p2;
  logic                    vld_p2;

  logic [OUT_W:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     sat_cnt;
  logic [CW:0]     occ;
  logic            accept;
  logic            push;
  logic            pop;

  // Credit counts everything in flight so the FIFO can never overflow and the pipe never stalls.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, vld_p1} + {{CW{1'b0}}, vld_p2};
  assign in_ready  = !rst && (occ < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign out_valid = !rst && (count != '0);
  assign push      = vld_p2;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr][OUT_W-1:0] : '0;
  assign out_sat   = out_valid ? mem[rd_ptr][OUT_W] : 1'b0;
  assign sat_count = sat_cnt;

  // Stage p1: round and shift
  always_ff @(posedge clk) begin
    if (accept)
      q_p1 <= round_shift($signed(in_data));
  end

  // Stage p2: saturate to output range
  always_ff @(posedge clk) begin
    if (vld_p1)
      {sat_p2, data_p2} <= saturate(q_p1);
  end

  // FIFO write stage
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {sat_p2, data_p2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_count)
      sat_cnt <= '0;
    else if (vld_p2 && sat_p2 && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 1'b1;
  end

endmodule

// File: tb/tb_filter_out_requant.sv
// Scoreboard bench for filter_out_requant: driver queues expected samples, monitor checks outputs.
module tb_filter_out_requant;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic        clr_count = 1'b0;
  logic [15:0] sat_count;

  filter_out_requant #(.IN_W(32), .OUT_W(16), .SHIFT(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .clr_count(clr_count), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  logic [16:0] sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    v = (v + 128) >>> 8;
    if (v > 32767) return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  // Monitor: credit check plus in-order compare of the head entry every cycle it is presented.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_credit", {31'd0, in_ready}, {31'd0, (sb.size() < 4)});
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_output: got %h expected none", {out_sat, out_data});
        end else begin
          check("out_sample", {15'd0, out_sat, out_data}, {15'd0, sb[0]});
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] x, input logic [16:0] e);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = x;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 500) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int          idx;
    logic        rdy_s;
    logic [31:0] x;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_out_sat",   {31'd0, out_sat},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_sat_count", {16'd0, sat_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Basic sample and rounding
    send(32'h00018000, {1'b0, 16'h0180});
    send(32'h00000080, {1'b0, 16'h0001});
    send(32'hFFFFFF80, {1'b0, 16'h0000});
    send(32'hFFFFFF7F, {1'b0, 16'hFFFF});
    send(32'h0000007F, {1'b0, 16'h0000});
    drain();

    // Saturation at both limits
    send(32'h00800000, {1'b1, 16'h7FFF});
    send(32'h7FFFFFFF, {1'b1, 16'h7FFF});
    send(32'hFF800000, {1'b0, 16'h8000});
    send(32'hFF7FFFFF, {1'b0, 16'h8000});
    send(32'hFF7FFF7F, {1'b1, 16'h8000});
    send(32'h80000000, {1'b1, 16'h8000});
    drain();
    check("sat_count_4", {16'd0, sat_count}, 32'd4);

    // Backpressure: only DEPTH samples may be in flight
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    in_data = 32'h100;
    repeat (10) begin
      @(negedge clk);
      rdy_s = in_ready;
      @(posedge clk);
      if (rdy_s && idx < 6) begin
        idx++;
        sb.push_back({1'b0, 16'(idx)});
      end
      #1;
      in_data = 32'(idx + 1) << 8;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", idx, 32'd4);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_data", {16'd0, out_data}, 32'h0001);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h500, {1'b0, 16'h0005});
    send(32'h600, {1'b0, 16'h0006});
    drain();

    // Random handshake toggling against the model
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      x = $urandom;
      case ($urandom_range(0, 2))
        0: x = {{9{x[31]}}, x[22:0]};
        1: x = {{17{x[31]}}, x[14:0]};
        default: ;
      endcase
      send(x, model(x));
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Counter saturation at 0xFFFF
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    check("clr_count", {16'd0, sat_count}, 32'd0);
    for (int i = 0; i < 65537; i++) send(32'h7FFFFFFF, {1'b1, 16'h7FFF});
    drain();
    check("sat_count_hold", {16'd0, sat_count}, 32'h0000FFFF);

    // Clear takes priority over a coincident clip
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    send(32'h80000000, {1'b1, 16'h8000});
    @(posedge clk); #1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    drain();
    check("clr_priority", {16'd0, sat_count}, 32'd0);

    // Reset with samples buffered
    out_ready = 1'b0;
    send(32'h00010000, {1'b0, 16'h0100});
    send(32'h00020000, {1'b0, 16'h0200});
    send(32'h00030000, {1'b0, 16'h0300});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {16'd0, out_data}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(32'h00040080, {1'b0, 16'h0401});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
